// File: rtl/lc3_system.sv
// LC-3 system: multi-cycle CPU, 64Kx16 unified memory (u_device), and memory-mapped
// keyboard/display registers brought out to the pads.

module lc3_mem #(
  parameter int unsigned MEM_WORDS = 65536
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);
  logic [15:0] mem [0:MEM_WORDS-1];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end
endmodule

module lc3_system #(
  parameter logic [15:0] RESET_PC  = 16'h3000,
  parameter int unsigned MEM_WORDS = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pad_kbdr,
  input  logic [15:0] pad_in_dsr,
  output logic [15:0] pad_kbsr,
  output logic [15:0] pad_ddr,
  output logic [15:0] pad_out_dsr
);
  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_MEM1, S_MEM2, S_HALT} state_e;
  typedef enum logic [3:0] {
    OP_BR, OP_ADD, OP_LD, OP_ST, OP_JSR, OP_AND, OP_LDR, OP_STR,
    OP_RTI, OP_NOT, OP_LDI, OP_STI, OP_JMP, OP_RES, OP_LEA, OP_TRAP
  } opcode_e;

  localparam logic [15:0] A_KBSR = 16'hFE00;
  localparam logic [15:0] A_KBDR = 16'hFE02;
  localparam logic [15:0] A_DSR  = 16'hFE04;
  localparam logic [15:0] A_DDR  = 16'hFE06;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [15:0] r_q [8];
  logic [15:0] r_d [8];
  logic [15:0] kbsr_q, kbsr_d, ddr_q, ddr_d, dsr_q, dsr_d, kbprev_q;
  logic        halted_q;

  opcode_e     opcode;
  logic [2:0]  dr, sr1, sr2;
  logic [15:0] off5, off6, off9, off11, op2, alu;
  logic [15:0] mem_addr, mem_rdata, load_data;
  logic        mem_we, access, is_load, is_store, io_hit, key_new;
  logic        dsr_unused;

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v[15])           return 3'b100;
    else if (v == 16'h0) return 3'b010;
    else                 return 3'b001;
  endfunction

  assign opcode   = opcode_e'(ir_q[15:12]);
  assign dr       = ir_q[11:9];
  assign sr1      = ir_q[8:6];
  assign sr2      = ir_q[2:0];
  assign off5     = {{11{ir_q[4]}}, ir_q[4:0]};
  assign off6     = {{10{ir_q[5]}}, ir_q[5:0]};
  assign off9     = {{7{ir_q[8]}}, ir_q[8:0]};
  assign off11    = {{5{ir_q[10]}}, ir_q[10:0]};
  assign op2      = ir_q[5] ? off5 : r_q[sr2];
  assign access   = (state_q == S_MEM) || (state_q == S_MEM2);
  assign is_load  = (opcode == OP_LD) || (opcode == OP_LDR) || (opcode == OP_LDI);
  assign is_store = (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);
  assign io_hit   = (mar_q == A_KBSR) || (mar_q == A_KBDR) || (mar_q == A_DSR) || (mar_q == A_DDR);
  assign key_new  = (pad_kbdr != 16'h0) && (pad_kbdr != kbprev_q);
  assign mem_addr = (state_q == S_FETCH) ? pc_q : mar_q;
  // Reset gates the write so an aborted store leaves memory untouched.
  assign mem_we   = access && is_store && !io_hit && !rst_n;
  assign dsr_unused = ^pad_in_dsr[14:0];

  assign pad_kbsr    = kbsr_q;
  assign pad_ddr     = ddr_q;
  assign pad_out_dsr = dsr_q;

  lc3_mem #(.MEM_WORDS(MEM_WORDS)) u_device (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (r_q[dr]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    case (mar_q)
      A_KBSR:  load_data = kbsr_q;
      A_KBDR:  load_data = pad_kbdr;
      A_DSR:   load_data = {pad_in_dsr[15], dsr_q[14:0]};
      A_DDR:   load_data = ddr_q;
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_ADD:  alu = r_q[sr1] + op2;
      OP_AND:  alu = r_q[sr1] & op2;
      OP_NOT:  alu = ~r_q[sr1];
      OP_LEA:  alu = pc_q + off9;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mar_q    <= '0;
      nzp_q    <= 3'b010;
      r_q      <= '{default: '0};
      kbsr_q   <= '0;
      ddr_q    <= '0;
      dsr_q    <= '0;
      kbprev_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mar_q    <= mar_d;
      nzp_q    <= nzp_d;
      r_q      <= r_d;
      kbsr_q   <= kbsr_d;
      ddr_q    <= ddr_d;
      dsr_q    <= dsr_d;
      kbprev_q <= pad_kbdr;
      halted_q <= (state_d == S_HALT);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_LD, OP_LDR, OP_ST, OP_STR: state_d = S_MEM;
          OP_LDI, OP_STI:               state_d = S_MEM1;
          OP_TRAP: state_d = (ir_q[7:0] == 8'h25) ? S_HALT : S_MEM;
          default:                      state_d = S_FETCH;
        endcase
      end
      S_MEM:   state_d = S_FETCH;
      S_MEM1:  state_d = S_MEM2;
      S_MEM2:  state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    mar_d  = mar_q;
    nzp_d  = nzp_q;
    r_d    = r_q;
    ddr_d  = ddr_q;
    dsr_d  = dsr_q;
    kbsr_d = kbsr_q;
    if (key_new) kbsr_d[15] = 1'b1;
    if (!halted_q) begin
      case (state_q)
        S_FETCH: begin
          ir_d = mem_rdata;
          pc_d = pc_q + 16'd1;
        end
        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: begin
              r_d[dr] = alu;
              nzp_d   = cc_of(alu);
            end
            OP_BR:  if ((ir_q[11:9] & nzp_q) != 3'b000) pc_d = pc_q + off9;
            OP_JMP: pc_d = r_q[sr1];
            OP_JSR: begin
              r_d[7] = pc_q;
              pc_d   = ir_q[11] ? pc_q + off11 : r_q[sr1];
            end
            OP_LD, OP_ST, OP_LDI, OP_STI: mar_d = pc_q + off9;
            OP_LDR, OP_STR:               mar_d = r_q[sr1] + off6;
            OP_TRAP: begin
              if (ir_q[7:0] != 8'h25) begin
                r_d[7] = pc_q;
                mar_d  = {8'h00, ir_q[7:0]};
              end
            end
            default: ;
          endcase
        end
        S_MEM1: mar_d = load_data;
        S_MEM, S_MEM2: begin
          if (is_load) begin
            r_d[dr] = load_data;
            nzp_d   = cc_of(load_data);
            // A KBDR read beats a key arriving in the same cycle.
            if (mar_q == A_KBDR) kbsr_d[15] = 1'b0;
          end
          if (is_store) begin
            case (mar_q)
              A_KBSR:  kbsr_d = r_q[dr];
              A_DSR:   dsr_d  = r_q[dr];
              A_DDR:   ddr_d  = r_q[dr];
              default: ;
            endcase
          end
          if (opcode == OP_TRAP) pc_d = load_data;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_system.sv
// Directed programs plus randomized ALU programs for lc3_system, checked against
// values computed from LC-3 instruction semantics.

module tb_lc3_system;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] pad_kbdr = '0;
  logic [15:0] pad_in_dsr = '0;
  logic [15:0] pad_kbsr, pad_ddr, pad_out_dsr;
  int total = 0;
  int bad = 0;

  lc3_system #(.RESET_PC(16'h3000), .MEM_WORDS(65536)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad_kbdr    (pad_kbdr),
    .pad_in_dsr  (pad_in_dsr),
    .pad_kbsr    (pad_kbsr),
    .pad_ddr     (pad_ddr),
    .pad_out_dsr (pad_out_dsr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] v);
    dut.u_device.mem[a] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_pc", dut.pc_q, 16'h3000);
    chk("rst_ddr", pad_ddr, 16'h0);
    chk("rst_dsr", pad_out_dsr, 16'h0);
    chk("rst_kbsr", pad_kbsr, 16'h0);
    rst_n = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dut.halted_q) break;
      @(posedge clk); #1;
    end
    chk(tag, {15'h0, dut.halted_q}, 16'h1);
  endtask

  function automatic logic [15:0] f_op(input logic [3:0] op, input logic [2:0] a, input logic [8:0] rest);
    return {op, a, rest};
  endfunction
  function automatic logic [15:0] f_imm(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s, input logic [4:0] imm);
    return {op, d, s, 1'b1, imm};
  endfunction
  function automatic logic [15:0] f_reg(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    return {op, d, s1, 3'b000, s2};
  endfunction
  function automatic logic [2:0] cc(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  initial begin
    logic [15:0] a, b, sum, ea;
    logic [4:0]  imm;
    logic signed [15:0] simm;

    // Program 1: 5 - 7 stored to x3010
    wr(16'h3000, f_imm(4'h5, 3'd0, 3'd0, 5'd0));
    wr(16'h3001, f_imm(4'h1, 3'd0, 3'd0, 5'd5));
    wr(16'h3002, f_imm(4'h1, 3'd0, 3'd0, 5'(-7)));
    wr(16'h3003, f_op(4'h3, 3'd0, 9'h00C));
    wr(16'h3004, 16'hF025);
    wr(16'h3010, 16'h1111);
    do_reset();
    chk("rst_ir", dut.ir_q, 16'h0);
    chk("rst_nzp", {13'h0, dut.nzp_q}, 16'h2);
    chk("rst_halt", {15'h0, dut.halted_q}, 16'h0);
    @(posedge clk); #1;
    chk("fetch_pc", dut.pc_q, 16'h3001);
    chk("fetch_ir", dut.ir_q, 16'h5020);
    wait_halt("p1_halt", 20);
    chk("p1_mem", dut.u_device.mem[16'h3010], 16'hFFFE);
    chk("p1_nzp", {13'h0, dut.nzp_q}, 16'h4);
    chk("p1_pc", dut.pc_q, 16'h3005);

    // Program 2: sum data words 1..10 with a BRp loop
    wr(16'h3000, f_op(4'hE, 3'd1, 9'h01F));
    wr(16'h3001, f_imm(4'h5, 3'd0, 3'd0, 5'd0));
    wr(16'h3002, f_imm(4'h5, 3'd2, 3'd2, 5'd0));
    wr(16'h3003, f_imm(4'h1, 3'd2, 3'd2, 5'd10));
    wr(16'h3004, {4'h6, 3'd3, 3'd1, 6'd0});
    wr(16'h3005, f_reg(4'h1, 3'd0, 3'd0, 3'd3));
    wr(16'h3006, f_imm(4'h1, 3'd1, 3'd1, 5'd1));
    wr(16'h3007, f_imm(4'h1, 3'd2, 3'd2, 5'(-1)));
    wr(16'h3008, f_op(4'h0, 3'b001, 9'(-5)));
    wr(16'h3009, f_op(4'h3, 3'd0, 9'h026));
    wr(16'h300A, 16'hF025);
    sum = 16'h0;
    for (int i = 0; i < 10; i++) begin
      wr(16'h3020 + 16'(i), 16'(i + 1));
      sum = sum + 16'(i + 1);
    end
    wr(16'h3030, 16'h0);
    do_reset();
    wait_halt("loop_halt", 200);
    chk("loop_sum", dut.u_device.mem[16'h3030], sum);
    chk("loop_pc", dut.pc_q, 16'h300B);
    repeat (10) @(posedge clk);
    #1 chk("loop_pc_frozen", dut.pc_q, 16'h300B);

    // Randomized ALU programs
    for (int n = 0; n < 6; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      imm = 5'($urandom_range(0, 31));
      simm = $signed(imm);
      wr(16'h3000, f_op(4'h2, 3'd0, 9'h00F));
      wr(16'h3001, f_op(4'h2, 3'd1, 9'h00F));
      wr(16'h3002, f_reg(4'h1, 3'd2, 3'd0, 3'd1));
      wr(16'h3003, f_reg(4'h5, 3'd3, 3'd0, 3'd1));
      wr(16'h3004, {4'h9, 3'd4, 3'd0, 6'h3F});
      wr(16'h3005, f_imm(4'h1, 3'd5, 3'd0, imm));
      wr(16'h3006, f_op(4'h3, 3'd2, 9'h00B));
      wr(16'h3007, 16'hF025);
      wr(16'h3010, a);
      wr(16'h3011, b);
      wr(16'h3012, 16'h0);
      do_reset();
      wait_halt("rnd_halt", 40);
      sum = a + 16'(simm);
      chk("rnd_add", dut.r_q[2], a + b);
      chk("rnd_and", dut.r_q[3], a & b);
      chk("rnd_not", dut.r_q[4], ~a);
      chk("rnd_addi", dut.r_q[5], sum);
      chk("rnd_st", dut.u_device.mem[16'h3012], a + b);
      chk("rnd_nzp", {13'h0, dut.nzp_q}, {13'h0, cc(sum)});
    end

    // Memory-mapped I/O
    wr(16'h3000, f_op(4'h2, 3'd1, 9'h00F));
    wr(16'h3001, f_op(4'hB, 3'd1, 9'h00F));
    wr(16'h3002, f_op(4'h2, 3'd2, 9'h00F));
    wr(16'h3003, f_op(4'hB, 3'd2, 9'h00F));
    wr(16'h3004, f_op(4'hA, 3'd4, 9'h00F));
    wr(16'h3005, f_op(4'hA, 3'd3, 9'h00F));
    wr(16'h3006, 16'hF025);
    wr(16'h3010, 16'h0041);
    wr(16'h3011, 16'hFE06);
    wr(16'h3012, 16'h8000);
    wr(16'h3013, 16'hFE04);
    wr(16'h3014, 16'hFE04);
    wr(16'h3015, 16'hFE02);
    do_reset();
    pad_kbdr = 16'h0061;
    @(posedge clk); #1;
    chk("kbsr_set", pad_kbsr, 16'h8000);
    wait_halt("io_halt", 60);
    chk("io_ddr", pad_ddr, 16'h0041);
    chk("io_dsr", pad_out_dsr, 16'h8000);
    chk("io_dsr_read", dut.r_q[4], 16'h0000);
    chk("io_kbdr", dut.r_q[3], 16'h0061);
    chk("io_kbsr_clr", pad_kbsr, 16'h0000);
    chk("io_nzp", {13'h0, dut.nzp_q}, 16'h1);
    pad_kbdr = 16'h0;

    // Reset asserted during the final access of an LDI
    wr(16'h3000, f_imm(4'h1, 3'd3, 3'd3, 5'd7));
    wr(16'h3001, f_op(4'hA, 3'd3, 9'h00E));
    wr(16'h3002, 16'hF025);
    wr(16'h3010, 16'h3011);
    wr(16'h3011, 16'h1234);
    do_reset();
    repeat (2) @(posedge clk);
    #1 chk("abort_pre", dut.r_q[3], 16'h0007);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_r3", dut.r_q[3], 16'h0000);
    chk("abort_pc", dut.pc_q, 16'h3000);
    chk("abort_ddr", pad_ddr, 16'h0);
    rst_n = 1'b0;
    wait_halt("abort_rerun_halt", 20);
    chk("abort_rerun_r3", dut.r_q[3], 16'h1234);

    // JSR / JMP R7 return, BR nzp=000 NOP, vectored TRAP
    wr(16'h3000, {4'h4, 1'b1, 11'h00F});
    wr(16'h3001, f_imm(4'h1, 3'd0, 3'd0, 5'd3));
    wr(16'h3002, f_op(4'h0, 3'b000, 9'h005));
    wr(16'h3003, 16'hF020);
    wr(16'h3010, f_imm(4'h1, 3'd1, 3'd1, 5'd1));
    wr(16'h3011, {4'hC, 3'd0, 3'd7, 6'd0});
    wr(16'h0020, 16'h3040);
    wr(16'h3040, 16'hF025);
    ea = 16'h3041;
    do_reset();
    wait_halt("jsr_halt", 40);
    chk("jsr_r0", dut.r_q[0], 16'h0003);
    chk("jsr_r1", dut.r_q[1], 16'h0001);
    chk("trap_r7", dut.r_q[7], 16'h3004);
    chk("trap_pc", dut.pc_q, ea);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
